// File: rtl/dram_image_wr_ctrl.sv
// Packs a serial pixel stream into 10-lane single-cycle write bursts for the image DRAM.
// Define WR_CTRL_PINGPONG_EN to keep accepting pixels during the burst cycle (1 pixel/clk).
module dram_image_wr_ctrl #(
   parameter int FRAME_PIXELS = 64000,
   parameter int BASE_WORD    = 0,
   parameter int LANES        = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  pix_valid,
   input  logic [15:0]           pix_data,
   output logic                  pix_ready,
   output logic                  ram_we,
   output logic [18*LANES-1:0]   ram_addr,
   output logic [16*LANES-1:0]   ram_wd,
   output logic                  busy,
   output logic                  frame_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [16:0] FRAME_W   = 17'(FRAME_PIXELS);
   localparam logic [16:0] BASE_W    = 17'(BASE_WORD);
   localparam logic [3:0]  LAST_LANE = 4'(LANES - 1);

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [16:0] wptr;
   logic [15:0] lane_buf [LANES];

   logic [16:0] wptr_sum;
   logic        frame_end;
   logic [16:0] eff_wptr;
   logic [3:0]  eff_cnt;
   logic        xfer;
   logic        grp_last;
   logic [18*LANES-1:0] nxt_addr;
   logic [16*LANES-1:0] nxt_wd;

   assign wptr_sum  = wptr + {13'd0, cnt};
   assign frame_end = (wptr_sum == FRAME_W);

   // During a burst the next group starts fresh at the advanced pointer
   always_comb begin
      eff_wptr = wptr;
      eff_cnt  = cnt;
      if (state == S_WRITE) begin
         eff_wptr = wptr_sum;
         eff_cnt  = 4'd0;
      end
   end

   always_comb begin
      pix_ready = 1'b0;
      unique case (1'b1)
         (state == S_FILL):  pix_ready = 1'b1;
`ifdef WR_CTRL_PINGPONG_EN
         (state == S_WRITE): pix_ready = !frame_end;
`else
         (state == S_WRITE): pix_ready = 1'b0;
`endif
         (state == S_IDLE):  pix_ready = 1'b0;
         (state == S_DONE):  pix_ready = 1'b0;
         default:            pix_ready = 1'b0;
      endcase
   end

   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_DONE);
   assign xfer       = pix_valid && pix_ready;

   assign grp_last = (eff_cnt == LAST_LANE) ||
                     ((eff_wptr + {13'd0, eff_cnt} + 17'd1) == FRAME_W);

   // Lanes past the last valid pixel repeat that pixel's address and data
   always_comb begin
      logic [15:0] aw;
      aw       = '0;
      nxt_addr = '0;
      nxt_wd   = '0;
      for (int k = 0; k < LANES; k++) begin
         if (4'(k) < eff_cnt) begin
            aw = 16'(BASE_W + eff_wptr + 17'(k));
            nxt_wd[16*k +: 16] = lane_buf[k];
         end else begin
            aw = 16'(BASE_W + eff_wptr + {13'd0, eff_cnt});
            nxt_wd[16*k +: 16] = pix_data;
         end
         nxt_addr[18*k +: 18] = {aw, 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         lane_buf[eff_cnt] <= pix_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         wptr     <= '0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_wd   <= '0;
      end else begin
         ram_we <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_FILL;
                  wptr  <= '0;
                  cnt   <= '0;
               end
            end
            S_FILL: begin
               if (xfer) begin
                  cnt <= cnt + 4'd1;
                  if (grp_last) begin
                     state    <= S_WRITE;
                     ram_we   <= 1'b1;
                     ram_addr <= nxt_addr;
                     ram_wd   <= nxt_wd;
                  end
               end
            end
            S_WRITE: begin
               wptr <= wptr_sum;
               if (xfer) begin
                  cnt <= 4'd1;
                  if (grp_last) begin
                     state    <= S_WRITE;
                     ram_we   <= 1'b1;
                     ram_addr <= nxt_addr;
                     ram_wd   <= nxt_wd;
                  end else begin
                     state <= S_FILL;
                  end
               end else begin
                  cnt   <= '0;
                  state <= frame_end ? S_DONE : S_FILL;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_image_wr_ctrl.sv
// Bench for dram_image_wr_ctrl: several frame geometries, each checked
// against burst contents derived from the accepted pixel list.
module tb_dram_image_wr_ctrl;

   localparam int N = 5;
`ifdef WR_CTRL_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   function automatic int fp_of(input int g);
      case (g)
         0: return 20;
         1: return 23;
         2: return 10;
         3: return 7;
         default: return 30;
      endcase
   endfunction

   function automatic int bw_of(input int g);
      case (g)
         2: return 100;
         3: return 65529;
         4: return 5;
         default: return 0;
      endcase
   endfunction

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start [N];
   logic         pix_valid [N];
   logic [15:0]  pix_data [N];
   logic         pix_ready [N];
   logic         ram_we [N];
   logic [179:0] ram_addr [N];
   logic [159:0] ram_wd [N];
   logic         busy [N];
   logic         frame_done [N];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      dram_image_wr_ctrl #(
         .FRAME_PIXELS(fp_of(g)),
         .BASE_WORD(bw_of(g))
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .start(start[g]),
         .pix_valid(pix_valid[g]),
         .pix_data(pix_data[g]),
         .pix_ready(pix_ready[g]),
         .ram_we(ram_we[g]),
         .ram_addr(ram_addr[g]),
         .ram_wd(ram_wd[g]),
         .busy(busy[g]),
         .frame_done(frame_done[g])
      );
   end

   task automatic chk(input string tag, input int g,
                      input logic [179:0] obs, input logic [179:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, g, obs, exp);
      end
   endtask

   task automatic chk_all_quiet();
      for (int i = 0; i < N; i++) begin
         chk("rst_we", i, ram_we[i], 0);
         chk("rst_busy", i, busy[i], 0);
         chk("rst_done", i, frame_done[i], 0);
         chk("rst_ready", i, pix_ready[i], 0);
         chk("rst_addr", i, ram_addr[i], 0);
         chk("rst_wd", i, ram_wd[i], 0);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < N; i++) begin
            start[i]     = 1'($urandom);
            pix_valid[i] = 1'($urandom);
            pix_data[i]  = 16'($urandom);
         end
         @(posedge clk); #1;
         chk_all_quiet();
      end
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         start[i] = 1'b0;
         pix_valid[i] = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk_all_quiet();
      end
   endtask

   // mode 0: valid held high, data 1..N; mode 1: valid toggling; mode 2: random
   task automatic run_frame(input int g, input int mode, input int restart_at);
      int fp, bw, acc, cyc, full_at, s, n, idx;
      bit xfer, exp_we, exp_done, prev_final, exp_ready;
      logic [15:0] pix [$];
      logic [179:0] ea;
      logic [159:0] ed;
      fp = fp_of(g);
      bw = bw_of(g);
      acc = 0;
      cyc = 0;
      full_at = -1;
      prev_final = 1'b0;
      exp_done = 1'b0;
      pix.delete();

      pix_valid[g] = 1'b1;
      pix_data[g]  = 16'hdead;
      @(posedge clk); #1;
      chk("idle_ready", g, pix_ready[g], 0);
      chk("idle_we", g, ram_we[g], 0);

      start[g] = 1'b1;
      pix_valid[g] = 1'b0;
      @(posedge clk); #1;
      start[g] = 1'b0;
      chk("start_busy", g, busy[g], 1);

      while (cyc < 3000) begin
         start[g] = (cyc == restart_at);
         case (mode)
            0: pix_valid[g] = 1'b1;
            1: pix_valid[g] = (cyc % 2 == 0);
            default: pix_valid[g] = 1'($urandom);
         endcase
         pix_data[g] = (mode == 0) ? 16'(acc + 1) : 16'($urandom);
         xfer = pix_valid[g] && pix_ready[g];
         if (xfer) pix.push_back(pix_data[g]);
         @(posedge clk); #1;
         cyc++;
         exp_we = 1'b0;
         if (xfer) begin
            acc++;
            if (acc % 10 == 0 || acc == fp) exp_we = 1'b1;
            if (acc == fp) full_at = cyc;
         end
         exp_done = prev_final;
         prev_final = exp_we && (acc == fp);
         exp_ready = !exp_done && (acc < fp) && (PP || !exp_we);
         chk("we", g, ram_we[g], exp_we);
         chk("done", g, frame_done[g], exp_done);
         chk("busy", g, busy[g], 1);
         chk("ready", g, pix_ready[g], exp_ready);
         if (exp_we) begin
            s = ((acc - 1) / 10) * 10;
            n = acc - s;
            for (int k = 0; k < 10; k++) begin
               idx = (k < n) ? k : n - 1;
               ea[18*k +: 18] = 18'((bw + s + idx) * 4);
               ed[16*k +: 16] = pix[s + idx];
            end
            chk("addr", g, ram_addr[g], ea);
            chk("wd", g, ram_wd[g], ed);
         end
         if (exp_done) break;
      end
      if (!exp_done) chk("timeout", g, 0, 1);

      start[g] = 1'b0;
      pix_valid[g] = 1'b0;
      @(posedge clk); #1;
      chk("end_busy", g, busy[g], 0);
      chk("end_we", g, ram_we[g], 0);
      chk("end_done", g, frame_done[g], 0);
      if (mode == 0)
         chk("accept_cycles", g, full_at, PP ? fp : fp + (fp + 9) / 10 - 1);
   endtask

   task automatic abort_frame(input int g, input int npix);
      int acc, cyc;
      acc = 0;
      cyc = 0;
      start[g] = 1'b1;
      @(posedge clk); #1;
      start[g] = 1'b0;
      while (acc < npix && cyc < 500) begin
         pix_valid[g] = 1'b1;
         pix_data[g]  = 16'($urandom);
         if (pix_ready[g]) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      if (acc < npix) chk("abort_timeout", g, 0, 1);
      chk("abort_busy", g, busy[g], 1);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         start[i] = 1'b0;
         pix_valid[i] = 1'b0;
         pix_data[i] = '0;
      end
      do_reset(2);
      run_frame(0, 0, -1);
      run_frame(1, 0, 5);
      run_frame(2, 1, -1);
      run_frame(3, 2, -1);
      run_frame(4, 0, -1);
      abort_frame(1, 13);
      do_reset(2);
      run_frame(1, 2, -1);
      run_frame(0, 2, -1);
      run_frame(4, 1, 12);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
